alu_result_mux_pipe: RTL and testbench
======================================

# alu_result_mux_pipe

Registered, parametrised successor to the ALU result selector: picks the write-back value from the ALU, shifter or HI/LO registers according to the function code, and buffers it in a one-entry output stage with valid/ready handshakes on both sides. It tracks outstanding DIVU operations and holds MFHI/MFLO at the input until the divider reports completion, so HI/LO is never read stale. It sits between the ALU datapath (ALU, Shifter, divider, HiLo) and the register-file write port.

## Interface
- WIDTH, 32, data width of all source operands and dataOut
- SIG_W, 6, width of Signal (function code)
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  asynchronous, active-low reset
- in_valid  in  1  Signal and sources are valid this cycle
- in_ready  out  1  block accepts the input this cycle (combinational)
- Signal  in  SIG_W  function code: AND 100100, OR 100101, ADD 100000, SUB 100010, SLT 101010, SRL 000010, DIVU 011011, MFHI 010000, MFLO 010010
- ALUOut  in  WIDTH  ALU result
- Shifter  in  WIDTH  shifter result
- HiOut  in  WIDTH  HI register value
- LoOut  in  WIDTH  LO register value
- div_done  in  1  one-cycle pulse from divider: HI/LO now hold the DIVU result
- out_valid  out  1  dataOut holds a result
- out_ready  in  1  consumer takes the result this cycle
- dataOut  out  WIDTH  registered selected result
- op_err  out  1  registered; current result came from an unknown function code
- hilo_pending  out  1  a DIVU has been accepted and div_done not yet seen

## Operation
- Accept = in_valid && in_ready.
- Selection on accept: AND/OR/ADD/SUB/SLT -> ALUOut; SRL -> Shifter; MFHI -> HiOut; MFLO -> LoOut; unknown code -> 0 with op_err=1.
- DIVU: accepted, produces no output beat; sets hilo_pending. out_valid/dataOut unaffected.
- Pending FSM, states IDLE (hilo_pending=0) and DIV_WAIT (hilo_pending=1):
  - IDLE -> DIV_WAIT on DIVU accept.
  - DIV_WAIT -> IDLE on div_done, unless a DIVU is accepted the same cycle (stays DIV_WAIT).
  - div_done in IDLE is ignored.
- in_ready = (!out_valid || out_ready) && !((Signal==MFHI || Signal==MFLO) && hilo_pending). Stalled MFHI/MFLO is accepted no earlier than the cycle after div_done.
- Non-HI/LO ops are never blocked by hilo_pending.
- Output register: loads on non-DIVU accept; out_valid clears when out_ready && out_valid with no new load. Simultaneous drain and load: out_valid stays 1, new data replaces old.
- dataOut, op_err hold while out_valid && !out_ready. in_valid dropped while stalled is legal; no state changes.

## Timing
- Latency: accept in cycle N -> out_valid, dataOut in cycle N+1.
- Throughput: 1 result/cycle while out_ready=1 and no HI/LO stall.
- MFHI after DIVU: div_done in cycle D -> earliest accept D+1 -> result D+2.
- Reset (reset=0, any time, asynchronous): out_valid=0, dataOut=0, op_err=0, hilo_pending=0, FSM IDLE; in-flight result and pending DIVU discarded. in_ready=1 while reset is asserted and out_valid=0.
- Outputs are glitch-free registers except in_ready.

## Configuration
- ALU_MUX_ZERO_EN defined: extra port zero (out, 1), registered with dataOut, 1 when the loaded result is all zeros, reset 0, held with dataOut.
- Undefined: no zero port. All other behaviour is identical.

## Test plan
- Reset then ADD, ALUOut=0x0000_0005, out_ready=1 -> next cycle out_valid=1, dataOut=5, op_err=0.
- Back-to-back SRL (Shifter=0x8) then MFLO (LoOut=0x3) with out_ready=0 for 2 cycles -> dataOut=0x8 held, in_ready=0, then 0x8 then 0x3 in consecutive cycles once out_ready=1.
- DIVU accepted, then MFHI presented (HiOut=0x7) -> in_ready=0 and hilo_pending=1 until div_done; accept the cycle after div_done; dataOut=0x7 one cycle later. An ADD issued during the wait is accepted immediately.
- DIVU accepted in the same cycle as div_done for an earlier DIVU -> hilo_pending stays 1.
- Signal=111111 -> dataOut=0, op_err=1. With ALU_MUX_ZERO_EN, SUB giving 0 -> zero=1.
- reset pulsed low mid-cycle while out_valid=1 and hilo_pending=1 -> out_valid, hilo_pending, dataOut drop to 0 immediately, before the next clk edge.

Source files
------------

// File: rtl/alu_result_mux_pipe.sv
// Registered write-back selector with a one-entry valid/ready output stage and DIVU tracking.
// Optional build macro ALU_MUX_ZERO_EN adds a registered all-zero flag port named zero.
module alu_result_mux_pipe #(
    parameter int WIDTH = 32,
    parameter int SIG_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [SIG_W-1:0] Signal,
    input  logic [WIDTH-1:0] ALUOut,
    input  logic [WIDTH-1:0] Shifter,
    input  logic [WIDTH-1:0] HiOut,
    input  logic [WIDTH-1:0] LoOut,
    input  logic             div_done,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] dataOut,
    output logic             op_err,
`ifdef ALU_MUX_ZERO_EN
    output logic             zero,
`endif
    output logic             hilo_pending
);

    localparam logic [SIG_W-1:0] F_AND  = SIG_W'(6'b100100);
    localparam logic [SIG_W-1:0] F_OR   = SIG_W'(6'b100101);
    localparam logic [SIG_W-1:0] F_ADD  = SIG_W'(6'b100000);
    localparam logic [SIG_W-1:0] F_SUB  = SIG_W'(6'b100010);
    localparam logic [SIG_W-1:0] F_SLT  = SIG_W'(6'b101010);
    localparam logic [SIG_W-1:0] F_SRL  = SIG_W'(6'b000010);
    localparam logic [SIG_W-1:0] F_DIVU = SIG_W'(6'b011011);
    localparam logic [SIG_W-1:0] F_MFHI = SIG_W'(6'b010000);
    localparam logic [SIG_W-1:0] F_MFLO = SIG_W'(6'b010010);

    typedef enum logic {IDLE, DIV_WAIT} state_t;
    state_t state;

    logic             is_divu;
    logic             is_hilo;
    logic             accept;
    logic [WIDTH-1:0] sel_data;
    logic             sel_err;

    assign is_divu = (Signal == F_DIVU);
    assign is_hilo = (Signal == F_MFHI) || (Signal == F_MFLO);
    // HI/LO reads wait while a divide is outstanding; everything else only needs output space
    assign in_ready = (!out_valid || out_ready) && !(is_hilo && hilo_pending);
    assign accept   = in_valid && in_ready;

    always_comb begin
        sel_data = '0;
        sel_err  = 1'b0;
        case (Signal)
            F_AND, F_OR, F_ADD, F_SUB, F_SLT: sel_data = ALUOut;
            F_SRL:                            sel_data = Shifter;
            F_MFHI:                           sel_data = HiOut;
            F_MFLO:                           sel_data = LoOut;
            F_DIVU:                           sel_data = '0;
            default:                          sel_err  = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            hilo_pending <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept && is_divu) begin
                        state        <= DIV_WAIT;
                        hilo_pending <= 1'b1;
                    end
                end
                DIV_WAIT: begin
                    // a fresh DIVU landing with the old one's completion keeps us waiting
                    if (div_done && !(accept && is_divu)) begin
                        state        <= IDLE;
                        hilo_pending <= 1'b0;
                    end
                end
                default: begin
                    state        <= IDLE;
                    hilo_pending <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid <= 1'b0;
            dataOut   <= '0;
            op_err    <= 1'b0;
`ifdef ALU_MUX_ZERO_EN
            zero      <= 1'b0;
`endif
        end else if (accept && !is_divu) begin
            out_valid <= 1'b1;
            dataOut   <= sel_data;
            op_err    <= sel_err;
`ifdef ALU_MUX_ZERO_EN
            zero      <= (sel_data == '0);
`endif
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_result_mux_pipe.sv
// Scoreboard bench for alu_result_mux_pipe: driver queues expected beats, monitor checks drained beats.
// Build with ALU_MUX_ZERO_EN defined to also exercise the zero flag.
module tb_alu_result_mux_pipe;

    localparam logic [5:0] C_AND  = 6'b100100;
    localparam logic [5:0] C_ADD  = 6'b100000;
    localparam logic [5:0] C_SUB  = 6'b100010;
    localparam logic [5:0] C_SRL  = 6'b000010;
    localparam logic [5:0] C_DIVU = 6'b011011;
    localparam logic [5:0] C_MFHI = 6'b010000;
    localparam logic [5:0] C_MFLO = 6'b010010;
    localparam logic [5:0] C_BAD  = 6'b111111;

    typedef struct {
        logic [31:0] d;
        logic        e;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [5:0]  Signal = C_AND;
    logic [31:0] ALUOut = '0;
    logic [31:0] Shifter = '0;
    logic [31:0] HiOut = '0;
    logic [31:0] LoOut = '0;
    logic        div_done = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] dataOut;
    logic        op_err;
    logic        hilo_pending;
`ifdef ALU_MUX_ZERO_EN
    logic        zero;
`endif

    int   tests = 0;
    int   fails = 0;
    exp_t q[$];

    alu_result_mux_pipe #(.WIDTH(32), .SIG_W(6)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .Signal(Signal), .ALUOut(ALUOut), .Shifter(Shifter), .HiOut(HiOut), .LoOut(LoOut),
        .div_done(div_done), .out_valid(out_valid), .out_ready(out_ready),
        .dataOut(dataOut), .op_err(op_err),
`ifdef ALU_MUX_ZERO_EN
        .zero(zero),
`endif
        .hilo_pending(hilo_pending)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Present one op from posedge+1; returns posedge+1 after the accepting edge.
    task automatic issue(input logic [5:0] sig, input logic [31:0] a, input logic [31:0] s,
                         input logic [31:0] h, input logic [31:0] l,
                         input logic [31:0] ed, input logic ee, output int waited);
        bit done = 0;
        exp_t x;
        Signal = sig; ALUOut = a; Shifter = s; HiOut = h; LoOut = l;
        in_valid = 1'b1;
        waited = 0;
        while (!done && waited < 50) begin
            @(negedge clk);
            if (in_ready) begin
                if (sig != C_DIVU) begin
                    x.d = ed; x.e = ee;
                    q.push_back(x);
                end
                done = 1;
            end else begin
                waited++;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        if (!done) check("issue_timeout", 32'd1, 32'd0);
    endtask

    always @(negedge clk) begin
        if (reset && out_valid && out_ready) begin
            if (q.size() == 0) begin
                check("unexpected_beat", dataOut, 32'hdeadbeef);
            end else begin
                exp_t x;
                x = q.pop_front();
                check("dataOut", dataOut, x.d);
                check("op_err", {31'b0, op_err}, {31'b0, x.e});
`ifdef ALU_MUX_ZERO_EN
                check("zero", {31'b0, zero}, {31'b0, (x.d == 32'd0)});
`endif
            end
        end
    end

    initial begin
        int w;
        int w2;
        #3;
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_dataOut", dataOut, 32'd0);
        check("rst_op_err", {31'b0, op_err}, 32'd0);
        check("rst_pending", {31'b0, hilo_pending}, 32'd0);
        check("rst_in_ready", {31'b0, in_ready}, 32'd1);
        @(posedge clk); #1;
        reset = 1'b1;

        // ADD with free output: result one cycle later
        issue(C_ADD, 32'h5, 32'h0, 32'h0, 32'h0, 32'h5, 1'b0, w);
        check("add_out_valid", {31'b0, out_valid}, 32'd1);
        check("add_dataOut", dataOut, 32'h5);
        repeat (2) @(posedge clk); #1;

        // SRL then MFLO with the consumer stalled for two cycles
        out_ready = 1'b0;
        issue(C_SRL, 32'h0, 32'h8, 32'h0, 32'h0, 32'h8, 1'b0, w);
        fork
            issue(C_MFLO, 32'h0, 32'h0, 32'h0, 32'h3, 32'h3, 1'b0, w);
            begin
                repeat (2) begin
                    @(negedge clk);
                    check("stall_in_ready", {31'b0, in_ready}, 32'd0);
                    check("stall_hold", dataOut, 32'h8);
                end
                @(posedge clk); #1;
                out_ready = 1'b1;
            end
        join
        check("mflo_wait", w, 32'd2);
        repeat (2) @(posedge clk); #1;

        // DIVU, ADD passes immediately, MFHI waits for div_done
        issue(C_DIVU, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, w);
        check("divu_pending", {31'b0, hilo_pending}, 32'd1);
        issue(C_ADD, 32'h11, 32'h0, 32'h0, 32'h0, 32'h11, 1'b0, w);
        check("add_not_blocked", w, 32'd0);
        fork
            issue(C_MFHI, 32'h0, 32'h0, 32'h7, 32'h0, 32'h7, 1'b0, w2);
            begin
                repeat (3) begin
                    @(negedge clk);
                    check("mfhi_blocked", {31'b0, in_ready}, 32'd0);
                    check("mfhi_pending", {31'b0, hilo_pending}, 32'd1);
                end
                @(posedge clk); #1;
                div_done = 1'b1;
                @(negedge clk);
                check("mfhi_blocked_on_done", {31'b0, in_ready}, 32'd0);
                @(posedge clk); #1;
                div_done = 1'b0;
            end
        join
        check("mfhi_wait", w2, 32'd4);
        check("pending_cleared", {31'b0, hilo_pending}, 32'd0);
        check("mfhi_next_cycle", dataOut, 32'h7);
        repeat (2) @(posedge clk); #1;

        // New DIVU coinciding with div_done keeps pending set
        issue(C_DIVU, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, w);
        fork
            issue(C_DIVU, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, w);
            begin
                div_done = 1'b1;
                @(posedge clk); #1;
                div_done = 1'b0;
            end
        join
        check("divu_overlap_pending", {31'b0, hilo_pending}, 32'd1);
        div_done = 1'b1;
        @(posedge clk); #1;
        div_done = 1'b0;
        check("divu_second_done", {31'b0, hilo_pending}, 32'd0);
        div_done = 1'b1;
        @(posedge clk); #1;
        div_done = 1'b0;
        check("idle_done_ignored", {31'b0, hilo_pending}, 32'd0);

        // Unknown code, then SUB producing zero
        issue(C_BAD, 32'h1234, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, w);
        check("bad_op_err", {31'b0, op_err}, 32'd1);
        issue(C_SUB, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, w);
        repeat (2) @(posedge clk); #1;

        // Asynchronous reset mid-cycle with a held result and a pending divide
        issue(C_DIVU, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, w);
        out_ready = 1'b0;
        issue(C_AND, 32'hff, 32'h0, 32'h0, 32'h0, 32'hff, 1'b0, w);
        check("pre_rst_valid", {31'b0, out_valid}, 32'd1);
        check("pre_rst_pending", {31'b0, hilo_pending}, 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check("arst_out_valid", {31'b0, out_valid}, 32'd0);
        check("arst_pending", {31'b0, hilo_pending}, 32'd0);
        check("arst_dataOut", dataOut, 32'd0);
        check("arst_in_ready", {31'b0, in_ready}, 32'd1);
        q.delete();
        @(posedge clk); #1;
        reset = 1'b1;
        out_ready = 1'b1;
        issue(C_ADD, 32'h42, 32'h0, 32'h0, 32'h0, 32'h42, 1'b0, w);
        repeat (3) @(posedge clk); #1;
        check("queue_drained", q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
